dvi_fifo_writer: RTL and testbench

- Producer end of the 44-bit pixel FIFO that sync_controller drains.
- Samples the incoming DVI pixel stream (de/hs/vs plus 8-bit RGB) and generates active-area x/y coordinates.
- Packs each kept pixel as {x[9:0], y[9:0], r[7:0], g[7:0], b[7:0]} and writes it to the FIFO write port under wrfull back-pressure.
- On overflow, drops the remainder of the frame so the reader never receives a torn frame.

---
 rtl/sync_pkg.sv | 54 +++++
 rtl/dvi_pixel_counter.sv | 95 +++++++++
 rtl/dvi_fifo_writer.sv | 156 +++++++++++++++
 tb/tb_dvi_fifo_writer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// ============================================================================
// Package : sync_pkg
// Shared widths, FIFO word field map, FSM encoding and helpers for the DVI
// pixel FIFO producer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sync_pkg;

  localparam int FIFO_W  = 44;
  localparam int COORD_W = 10;
  localparam int CNT_W   = 11;

  localparam int X_MSB = 43;
  localparam int X_LSB = 34;
  localparam int Y_MSB = 33;
  localparam int Y_LSB = 24;
  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] S_SYNC   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DROP   = 2'd2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Counters stop at all-ones so an overrun line/column can never alias to 0.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [FIFO_W-1:0] pack_word(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y,
                                                  input rgb_t              rgb);
    return {x, y, rgb.r, rgb.g, rgb.b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dvi_pixel_counter.sv
// ============================================================================
// Module : dvi_pixel_counter
// Registers the DVI inputs, detects de/vs edges and tracks x/y coordinates.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dvi_pixel_counter
  import sync_pkg::*;
#(
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_de,
  input  logic             in_vs,
  input  logic [23:0]      in_rgb,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             de_q,
  output logic             vs_q,
  output logic [23:0]      rgb_q,
  output logic             frame_start,
  output logic             line_end
);

  logic             vs_norm;
  logic             de_d;
  logic             vs_d;
  logic [23:0]      rgb_d;
  logic             de_dly_d;
  logic             de_dly_q;
  logic             vs_dly_d;
  logic             vs_dly_q;
  logic [CNT_W-1:0] x_d;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_d;
  logic [CNT_W-1:0] y_q;

  generate
    if (VS_ACTIVE_LOW != 0) begin : g_vs_inv
      assign vs_norm = ~in_vs;
    end else begin : g_vs_pass
      assign vs_norm = in_vs;
    end
  endgenerate

  assign frame_start = vs_dly_q & ~vs_q;
  assign line_end    = de_dly_q & ~de_q;
  assign x           = x_q;
  assign y           = y_q;

  always_comb begin
    de_d     = in_de;
    vs_d     = vs_norm;
    rgb_d    = in_rgb;
    de_dly_d = de_q;
    vs_dly_d = vs_q;
    x_d      = x_q;
    y_d      = y_q;
    // Active vsync dominates: a pixel coinciding with vs never advances x.
    if (vs_q) begin
      x_d = '0;
      y_d = '0;
    end else if (line_end) begin
      x_d = '0;
      y_d = sat_inc(y_q);
    end else if (de_q) begin
      x_d = sat_inc(x_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q     <= 1'b0;
      vs_q     <= 1'b0;
      rgb_q    <= '0;
      de_dly_q <= 1'b0;
      vs_dly_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      de_q     <= de_d;
      vs_q     <= vs_d;
      rgb_q    <= rgb_d;
      de_dly_q <= de_dly_d;
      vs_dly_q <= vs_dly_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dvi_fifo_writer.sv
// ============================================================================
// Module : dvi_fifo_writer
// Writes kept DVI pixels as {x,y,r,g,b} FIFO words; drops the rest of a frame
// on overflow. Define DVI_FIFO_WRITER_TESTPAT_EN for a coordinate test pattern.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dvi_fifo_writer
  import sync_pkg::*;
#(
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int VS_ACTIVE_LOW = 1,
  parameter int SUB_SHIFT     = 0
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic        in_de,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic        wrfull,
  output logic        wrclk,
  output logic        wrreq,
  output logic [43:0] data,
  output logic        overflow,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] H_LIM  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LIM  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE - 1);

  logic [CNT_W-1:0]  x;
  logic [CNT_W-1:0]  y;
  logic              de_q;
  logic              vs_q;
  logic [23:0]       rgb_q;
  logic              frame_start;
  logic              line_end;
  logic              sub_ok;
  logic              keep;
  rgb_t              pix_rgb;

  logic [1:0]        state_d;
  logic [1:0]        state_q;
  logic              wrreq_d;
  logic              wrreq_q;
  logic [FIFO_W-1:0] data_d;
  logic [FIFO_W-1:0] data_q;
  logic              overflow_d;
  logic              overflow_q;
  logic              frame_done_d;
  logic              frame_done_q;

  logic              unused_hs;
  assign unused_hs = in_hs;

  dvi_pixel_counter #(
    .VS_ACTIVE_LOW(VS_ACTIVE_LOW)
  ) u_counter (
    .clk        (clk_25),
    .rst_n      (rst_n),
    .in_de      (in_de),
    .in_vs      (in_vs),
    .in_rgb     ({in_r, in_g, in_b}),
    .x          (x),
    .y          (y),
    .de_q       (de_q),
    .vs_q       (vs_q),
    .rgb_q      (rgb_q),
    .frame_start(frame_start),
    .line_end   (line_end)
  );

  generate
    if (SUB_SHIFT == 0) begin : g_sub_all
      assign sub_ok = 1'b1;
    end else begin : g_sub_mask
      localparam logic [CNT_W-1:0] SUB_MASK = CNT_W'((1 << SUB_SHIFT) - 1);
      assign sub_ok = ((x & SUB_MASK) == '0) && ((y & SUB_MASK) == '0);
    end
  endgenerate

`ifdef DVI_FIFO_WRITER_TESTPAT_EN
  logic unused_rgb;
  assign unused_rgb = ^rgb_q;
  assign pix_rgb    = {x[7:0], y[7:0], x[7:0] ^ y[7:0]};
`else
  assign pix_rgb    = rgb_q;
`endif

  assign keep = de_q && !vs_q && (state_q == S_ACTIVE) &&
                (x < H_LIM) && (y < V_LIM) && sub_ok;

  always_comb begin
    state_d      = state_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    wrreq_d      = 1'b0;
    data_d       = data_q;
    case (state_q)
      S_SYNC: begin
        if (frame_start) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        // An early vsync aborts the frame silently; the reader never sees a done.
        if (vs_q) begin
          state_d = S_SYNC;
        end else if (keep && wrfull) begin
          overflow_d = 1'b1;
          state_d    = S_DROP;
        end else if (line_end && (y == V_LAST)) begin
          frame_done_d = 1'b1;
          state_d      = S_SYNC;
        end
      end
      S_DROP: begin
        if (frame_start) state_d = S_ACTIVE;
      end
      default: state_d = S_SYNC;
    endcase
    if (keep && !wrfull) begin
      wrreq_d = 1'b1;
      data_d  = pack_word(x[COORD_W-1:0], y[COORD_W-1:0], pix_rgb);
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SYNC;
      wrreq_q      <= 1'b0;
      data_q       <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrreq_q      <= wrreq_d;
      data_q       <= data_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wrclk      = clk_25;
  assign wrreq      = wrreq_q;
  assign data       = data_q;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_dvi_fifo_writer.sv
// ============================================================================
// Module : tb_dvi_fifo_writer
// Self-checking bench for dvi_fifo_writer: two instances (4x2 full-rate and
// 4x4 with SUB_SHIFT=1) against a stream-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dvi_fifo_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_de, in_hs, in_vs, wrfull;
  logic [7:0]  in_r, in_g, in_b;

  logic        wrclk0, wrreq0, ovf0, fd0;
  logic [43:0] data0;
  logic        wrclk1, wrreq1, ovf1, fd1;
  logic [43:0] data1;

  always #5 clk = ~clk;

  dvi_fifo_writer #(.H_ACTIVE(4), .V_ACTIVE(2), .VS_ACTIVE_LOW(1), .SUB_SHIFT(0)) dut0 (
    .clk_25(clk), .rst_n(rst_n), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .wrfull(wrfull),
    .wrclk(wrclk0), .wrreq(wrreq0), .data(data0), .overflow(ovf0), .frame_done(fd0)
  );

  dvi_fifo_writer #(.H_ACTIVE(4), .V_ACTIVE(4), .VS_ACTIVE_LOW(1), .SUB_SHIFT(1)) dut1 (
    .clk_25(clk), .rst_n(rst_n), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .wrfull(wrfull),
    .wrclk(wrclk1), .wrreq(wrreq1), .data(data1), .overflow(ovf1), .frame_done(fd1)
  );

  // Stream-level model: mode 0=waiting for frame start, 1=writing, 2=dropping.
  typedef struct {
    int          mode;
    int          px;
    int          ln;
    bit          pde, pvs;
    bit          sde, svs;
    logic [7:0]  sr, sg, sb;
    bit          wr;
    logic [43:0] data;
    bit          ovf;
    bit          fd;
  } model_t;

  typedef struct {
    int lines, de_len, fx, fy, vx, vy;
    int w0, w1, f0, f1;
    bit o0, o1;
  } vec_t;

  model_t m0, m1;
  int     n_vec = 0;
  int     n_err = 0;
  int     wc0, wc1, fc0, fc1;

  task automatic model_reset(inout model_t m);
    m.mode = 0; m.px = 0; m.ln = 0;
    m.pde = 0; m.pvs = 0; m.sde = 0; m.svs = 0;
    m.sr = 0; m.sg = 0; m.sb = 0;
    m.wr = 0; m.data = '0; m.ovf = 0; m.fd = 0;
  endtask

  // Consumes the sample taken one edge earlier; full is the flag seen now.
  task automatic model_step(inout model_t m, input int h, input int v, input int sub,
                            input bit de, input bit vs, input logic [7:0] r,
                            input logic [7:0] g, input logic [7:0] b, input bit full);
    int         step;
    logic [7:0] pr, pg, pb;
    step = 1 << sub;
    m.wr = 0;
    m.fd = 0;
    if (m.svs) begin
      if (m.mode == 1) m.mode = 0;
      m.px = 0;
      m.ln = 0;
    end else begin
      if (m.pde && !m.sde) begin
        if (m.mode == 1 && m.ln == v - 1) begin
          m.fd   = 1;
          m.mode = 0;
        end
        m.px = 0;
        m.ln = m.ln + 1;
      end else if (m.sde) begin
        if (m.mode == 1 && m.px < h && m.ln < v && (m.px % step) == 0 && (m.ln % step) == 0) begin
          if (full) begin
            m.ovf  = 1;
            m.mode = 2;
          end else begin
`ifdef DVI_FIFO_WRITER_TESTPAT_EN
            pr = 8'(m.px); pg = 8'(m.ln); pb = pr ^ pg;
`else
            pr = m.sr; pg = m.sg; pb = m.sb;
`endif
            m.wr   = 1;
            m.data = {10'(m.px), 10'(m.ln), pr, pg, pb};
          end
        end
        m.px = m.px + 1;
      end
      if (m.pvs) m.mode = 1;
    end
    m.pde = m.sde; m.pvs = m.svs;
    m.sde = de; m.svs = vs; m.sr = r; m.sg = g; m.sb = b;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("dut0.wrclk", wrclk0, clk);
    check("dut0.wrreq", wrreq0, m0.wr);
    check("dut0.data", data0, m0.data);
    check("dut0.overflow", ovf0, m0.ovf);
    check("dut0.frame_done", fd0, m0.fd);
    check("dut1.wrreq", wrreq1, m1.wr);
    check("dut1.data", data1, m1.data);
    check("dut1.overflow", ovf1, m1.ovf);
    check("dut1.frame_done", fd1, m1.fd);
  endtask

  task automatic cyc(input bit de, input bit vs, input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b, input bit full);
    in_de  = de;
    in_vs  = ~vs;
    in_hs  = 1'($urandom);
    in_r   = r;
    in_g   = g;
    in_b   = b;
    wrfull = full;
    @(posedge clk);
    if (rst_n) begin
      model_step(m0, 4, 2, 0, de, vs, r, g, b, full);
      model_step(m1, 4, 4, 1, de, vs, r, g, b, full);
    end else begin
      model_reset(m0);
      model_reset(m1);
    end
    @(negedge clk);
    compare_all();
    if (wrreq0) wc0++;
    if (wrreq1) wc1++;
    if (fd0) fc0++;
    if (fd1) fc1++;
  endtask

  task automatic blank(input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 8'h00, 8'h00, 8'h00, rnd && ($urandom_range(0, 5) == 0));
  endtask

  // One vs pulse, then lines of de_len pixels; fx/fy marks the pixel lost to
  // wrfull, vx/vy the pixel where vs arrives early (-1 disables either).
  task automatic gen_frame(input int lines, input int de_len, input int fx, input int fy,
                           input int vx, input int vy, input bit rnd);
    bit fnext;
    bit tvs;
    fnext = 0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h00, 8'h00, 8'h00, rnd && ($urandom_range(0, 5) == 0));
    blank(3, rnd);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < de_len; p++) begin
        tvs = (l == vy) && (p == vx);
        cyc(1, tvs, 8'($urandom), 8'($urandom), 8'($urandom),
            fnext || (rnd && ($urandom_range(0, 5) == 0)));
        fnext = (l == fy) && (p == fx);
        if (tvs) begin
          for (int i = 0; i < 2; i++) cyc(0, 1, 8'h00, 8'h00, 8'h00, fnext);
          blank(4, rnd);
          return;
        end
      end
      cyc(0, 0, 8'h00, 8'h00, 8'h00, fnext);
      fnext = 0;
      blank(2, rnd);
    end
    blank(3, rnd);
  endtask

  vec_t vecs[7];
  int   rl, rd, rvx, rvy;

  initial begin
    vecs[0] = '{lines:2, de_len:4, fx:-1, fy:-1, vx:-1, vy:-1, w0:8, w1:2, f0:1, f1:0, o0:0, o1:0};
    vecs[1] = '{lines:1, de_len:6, fx:-1, fy:-1, vx:-1, vy:-1, w0:4, w1:2, f0:0, f1:0, o0:0, o1:0};
    vecs[2] = '{lines:4, de_len:4, fx:-1, fy:-1, vx:-1, vy:-1, w0:8, w1:4, f0:1, f1:1, o0:0, o1:0};
    vecs[3] = '{lines:2, de_len:4, fx:2,  fy:0,  vx:-1, vy:-1, w0:2, w1:1, f0:0, f1:0, o0:1, o1:1};
    vecs[4] = '{lines:2, de_len:4, fx:-1, fy:-1, vx:-1, vy:-1, w0:8, w1:2, f0:1, f1:0, o0:1, o1:1};
    vecs[5] = '{lines:2, de_len:4, fx:-1, fy:-1, vx:1,  vy:1,  w0:5, w1:2, f0:0, f1:0, o0:1, o1:1};
    vecs[6] = '{lines:2, de_len:4, fx:-1, fy:-1, vx:-1, vy:-1, w0:8, w1:2, f0:1, f1:0, o0:1, o1:1};

    rst_n = 1'b0; in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b1; wrfull = 1'b0;
    in_r = 8'h00; in_g = 8'h00; in_b = 8'h00;
    model_reset(m0);
    model_reset(m1);
    #1;
    check("reset.wrreq", wrreq0, 1'b0);
    check("reset.data", data0, 44'd0);
    check("reset.overflow", ovf0, 1'b0);
    check("reset.frame_done", fd0, 1'b0);
    @(negedge clk);
    blank(2, 0);
    rst_n = 1'b1;
    blank(2, 0);

    for (int i = 0; i < 7; i++) begin
      wc0 = 0; wc1 = 0; fc0 = 0; fc1 = 0;
      gen_frame(vecs[i].lines, vecs[i].de_len, vecs[i].fx, vecs[i].fy, vecs[i].vx, vecs[i].vy, 0);
      check($sformatf("vec%0d.writes0", i), wc0, vecs[i].w0);
      check($sformatf("vec%0d.writes1", i), wc1, vecs[i].w1);
      check($sformatf("vec%0d.done0", i), fc0, vecs[i].f0);
      check($sformatf("vec%0d.done1", i), fc1, vecs[i].f1);
      check($sformatf("vec%0d.ovf0", i), ovf0, vecs[i].o0);
      check($sformatf("vec%0d.ovf1", i), ovf1, vecs[i].o1);
    end

    // Reset in the middle of line 1, released mid-line.
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h00, 8'h00, 8'h00, 0);
    blank(3, 0);
    for (int p = 0; p < 4; p++) cyc(1, 0, 8'($urandom), 8'($urandom), 8'($urandom), 0);
    blank(3, 0);
    cyc(1, 0, 8'h11, 8'h22, 8'h33, 0);
    rst_n = 1'b0;
    model_reset(m0);
    model_reset(m1);
    #1;
    check("midreset.wrreq", wrreq0, 1'b0);
    check("midreset.data", data0, 44'd0);
    check("midreset.overflow", ovf0, 1'b0);
    check("midreset.ovf1", ovf1, 1'b0);
    check("midreset.frame_done", fd0, 1'b0);
    @(negedge clk);
    cyc(1, 0, 8'h44, 8'h55, 8'h66, 0);
    rst_n = 1'b1;
    wc0 = 0; wc1 = 0;
    for (int p = 0; p < 2; p++) cyc(1, 0, 8'($urandom), 8'($urandom), 8'($urandom), 0);
    blank(3, 0);
    for (int p = 0; p < 4; p++) cyc(1, 0, 8'($urandom), 8'($urandom), 8'($urandom), 0);
    blank(3, 0);
    check("postreset.nowrite0", wc0, 0);
    check("postreset.nowrite1", wc1, 0);
    wc0 = 0; fc0 = 0;
    gen_frame(2, 4, -1, -1, -1, -1, 0);
    check("postreset.writes0", wc0, 8);
    check("postreset.done0", fc0, 1);
    check("postreset.ovf0", ovf0, 1'b0);

    // Randomised frames with random back-pressure and occasional early vsync.
    for (int k = 0; k < 12; k++) begin
      rl  = $urandom_range(1, 5);
      rd  = $urandom_range(2, 7);
      rvx = -1;
      rvy = -1;
      if ($urandom_range(0, 3) == 0) begin
        rvx = $urandom_range(0, rd - 1);
        rvy = $urandom_range(0, rl - 1);
      end
      gen_frame(rl, rd, -1, -1, rvx, rvy, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
